// File: rtl/softmax_stream_feeder_pkg.sv
// softmax_stream_feeder_pkg: state encoding and default sizes shared with the softmax pipeline top
package softmax_stream_feeder_pkg;
  localparam int def_data_size = 32;
  localparam int def_number_of_data = 10;
  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/softmax_vector_buffer.sv
// softmax_vector_buffer: number_of_data x data_size register file, one write port, one combinational read port
module softmax_vector_buffer #(
  parameter int data_size = 32,
  parameter int number_of_data = 10,
  parameter int addr_width = $clog2(number_of_data + 1)
) (
  input  logic                  clock_i,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_size-1:0]  wr_data,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_size-1:0]  rd_data
);
  logic [data_size-1:0] mem [number_of_data];
  always_ff @(posedge clock_i)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/softmax_stream_feeder.sv
// softmax_stream_feeder: buffers one host vector, streams it to the softmax pipeline with start_o,
// then counts returned result words and flags frame completion and overruns.
module softmax_stream_feeder
  import softmax_stream_feeder_pkg::*;
#(
  parameter int data_size = def_data_size,
  parameter int number_of_data = def_number_of_data,
  parameter int cnt_width = $clog2(number_of_data + 1)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic                 start_o,
  output logic [data_size-1:0] data_o,
  input  logic [data_size-1:0] result_data_i,
  input  logic                 result_valid_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [data_size-1:0] last_result_o,
  output logic                 overrun_o
);
  localparam logic [cnt_width-1:0] last_idx = cnt_width'(number_of_data - 1);
  feeder_state_e state_q, state_d;
  logic [cnt_width-1:0] wr_cnt_q, wr_cnt_d, snd_cnt_q, snd_cnt_d, res_cnt_q, res_cnt_d, rd_addr;
  logic [data_size-1:0] data_q, data_d, last_result_q, last_result_d, rd_data;
  logic start_q, start_d, busy_q, busy_d, frame_done_q, frame_done_d, overrun_q, overrun_d, wr_en;

  assign wr_ready_o = state_q == FILL;
  assign wr_en = wr_ready_o && wr_valid_i;
  // snd_cnt_q indexes the word on data_o, so the buffer is read one word ahead
  assign rd_addr = (state_q == SEND && snd_cnt_q != last_idx) ? snd_cnt_q + cnt_width'(1) : '0;

  softmax_vector_buffer #(
    .data_size(data_size), .number_of_data(number_of_data), .addr_width(cnt_width)
  ) u_buf (
    .clock_i(clock_i), .wr_en(wr_en), .wr_addr(wr_cnt_q), .wr_data(wr_data_i),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always_comb begin
    state_d = state_q;
    wr_cnt_d = wr_cnt_q;
    snd_cnt_d = snd_cnt_q;
    res_cnt_d = res_cnt_q;
    start_d = 1'b0;
    data_d = '0;
    frame_done_d = 1'b0;
    last_result_d = last_result_q;
    overrun_d = overrun_q || (result_valid_i && state_q != WAIT);
    case (state_q)
      FILL: if (wr_en) begin
        wr_cnt_d = wr_cnt_q == last_idx ? '0 : wr_cnt_q + cnt_width'(1);
        if (wr_cnt_q == last_idx) begin
          state_d = SEND;
          snd_cnt_d = '0;
          start_d = 1'b1;
          data_d = rd_data;
        end
      end
      SEND: if (snd_cnt_q == last_idx) begin
        state_d = WAIT;
        snd_cnt_d = '0;
      end else begin
        snd_cnt_d = snd_cnt_q + cnt_width'(1);
        start_d = 1'b1;
        data_d = rd_data;
      end
      WAIT: if (result_valid_i) begin
        last_result_d = result_data_i;
        res_cnt_d = res_cnt_q == last_idx ? '0 : res_cnt_q + cnt_width'(1);
        frame_done_d = res_cnt_q == last_idx;
        state_d = res_cnt_q == last_idx ? FILL : WAIT;
      end
      default: state_d = FILL;
    endcase
    busy_d = state_d != FILL;
  end

  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= FILL;
      wr_cnt_q <= '0;
      snd_cnt_q <= '0;
      res_cnt_q <= '0;
      start_q <= 1'b0;
      data_q <= '0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      last_result_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      snd_cnt_q <= snd_cnt_d;
      res_cnt_q <= res_cnt_d;
      start_q <= start_d;
      data_q <= data_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      last_result_q <= last_result_d;
      overrun_q <= overrun_d;
    end

  assign start_o = start_q;
  assign data_o = data_q;
  assign busy_o = busy_q;
  assign frame_done_o = frame_done_q;
  assign last_result_o = last_result_q;
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_softmax_stream_feeder.sv
// tb_softmax_stream_feeder: directed frames with hand-computed expectations for the stream feeder
module tb_softmax_stream_feeder;
  logic clock_i = 1'b0, reset_n_i = 1'b0, wr_valid_i = 1'b0, result_valid_i = 1'b0;
  logic [31:0] wr_data_i = '0, result_data_i = '0;
  logic wr_ready_o, start_o, busy_o, frame_done_o, overrun_o;
  logic [31:0] data_o, last_result_o;
  int errors = 0, checks = 0;

  softmax_stream_feeder dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .start_o(start_o), .data_o(data_o), .result_data_i(result_data_i),
    .result_valid_i(result_valid_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .last_result_o(last_result_o), .overrun_o(overrun_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input bit gap);
    for (int i = 0; i < 10; i++) begin
      if (gap && i > 0) begin
        wr_valid_i = 1'b0;
        step();
      end
      wr_valid_i = 1'b1;
      wr_data_i = base + 32'(i);
      check("fill_ready", {31'b0, wr_ready_o}, 32'd1);
      step();
      check("fill_done_low", {31'b0, frame_done_o}, 32'd0);
      if (i < 9) check("fill_start_low", {31'b0, start_o}, 32'd0);
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] base, input int abort_k);
    for (int k = 0; k < 10; k++) begin
      if (k == abort_k) return;
      check("send_start", {31'b0, start_o}, 32'd1);
      check("send_data", data_o, base + 32'(k));
      check("send_busy", {31'b0, busy_o}, 32'd1);
      check("send_ready", {31'b0, wr_ready_o}, 32'd0);
      step();
    end
    check("wait_start", {31'b0, start_o}, 32'd0);
    check("wait_data", data_o, 32'd0);
    check("wait_busy", {31'b0, busy_o}, 32'd1);
  endtask

  task automatic results(input logic [31:0] first, input bit gap, input bit hold_wr);
    for (int i = 0; i < 10; i++) begin
      result_valid_i = 1'b1;
      result_data_i = first + 32'(i);
      wr_valid_i = hold_wr;
      wr_data_i = 32'hDEAD_0000 + 32'(i);
      check("wait_ready", {31'b0, wr_ready_o}, 32'd0);
      step();
      result_valid_i = 1'b0;
      check("res_last", last_result_o, first + 32'(i));
      if (i < 9) begin
        check("res_done_low", {31'b0, frame_done_o}, 32'd0);
        check("res_busy", {31'b0, busy_o}, 32'd1);
        if (gap) begin
          step();
          check("gap_done_low", {31'b0, frame_done_o}, 32'd0);
        end
      end
    end
    wr_valid_i = 1'b0;
    check("frame_done", {31'b0, frame_done_o}, 32'd1);
    check("done_ready", {31'b0, wr_ready_o}, 32'd1);
    check("done_busy", {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #3;
    check("rst_ready", {31'b0, wr_ready_o}, 32'd1);
    check("rst_start", {31'b0, start_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, frame_done_o}, 32'd0);
    check("rst_last", last_result_o, 32'd0);
    check("rst_overrun", {31'b0, overrun_o}, 32'd0);
    repeat (2) @(posedge clock_i);
    #1 reset_n_i = 1'b1;
    step();
    fill(32'd1, 1'b0);
    send(32'd1, -1);
    results(32'hA0, 1'b1, 1'b0);
    check("no_overrun", {31'b0, overrun_o}, 32'd0);
    step();
    check("done_pulse_end", {31'b0, frame_done_o}, 32'd0);
    result_valid_i = 1'b1;
    result_data_i = 32'hFF;
    step();
    result_valid_i = 1'b0;
    check("overrun_set", {31'b0, overrun_o}, 32'd1);
    check("overrun_last", last_result_o, 32'hA9);
    check("overrun_ready", {31'b0, wr_ready_o}, 32'd1);
    fill(32'd100, 1'b1);
    send(32'd100, -1);
    results(32'hB0, 1'b0, 1'b0);
    check("overrun_sticky", {31'b0, overrun_o}, 32'd1);
    fill(32'd31, 1'b0);
    send(32'd31, 3);
    reset_n_i = 1'b0;
    #1;
    check("arst_start", {31'b0, start_o}, 32'd0);
    check("arst_data", data_o, 32'd0);
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    check("arst_ready", {31'b0, wr_ready_o}, 32'd1);
    check("arst_overrun", {31'b0, overrun_o}, 32'd0);
    step();
    reset_n_i = 1'b1;
    step();
    fill(32'd11, 1'b0);
    send(32'd11, -1);
    results(32'hC0, 1'b1, 1'b1);
    fill(32'd41, 1'b0);
    send(32'd41, -1);
    results(32'hD0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/softmax_stream_feeder.md
Name: softmax_stream_feeder

Overview:
- Source end of the softmax pipeline's input interface (start_i / data_i). It buffers one vector of number_of_data words from a valid/ready host write port.
- It streams the vector into the pipeline with start_o framing, then counts result words returned on the pipeline's output valid.
- It reports frame completion and overrun errors.
- One frame is in flight at a time; a single buffer is used.

Parameters:
- data_size, 32, width of every data word.
- number_of_data, 10, words per vector (must be at least 2).
- cnt_width, $clog2(number_of_data+1), width of the word, send and result counters.

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- wr_data_i  input  data_size  host write word.
- wr_valid_i  input  1  host word valid.
- wr_ready_o  output  1  feeder can accept a word.
- start_o  output  1  frame strobe to pipeline start_i; high for every cycle that carries a vector word.
- data_o  output  data_size  vector word to pipeline data_i.
- result_data_i  input  data_size  pipeline output word (sub_2_data_o).
- result_valid_i  input  1  pipeline output valid (sub_2_data_valid_o).
- busy_o  output  1  high in SEND or WAIT.
- frame_done_o  output  1  one-cycle pulse when the last result word of a frame arrives.
- last_result_o  output  data_size  copy of the most recent result word captured in WAIT.
- overrun_o  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, active-low):
  - state=FILL; all counters 0.
  - wr_ready_o=1; start_o=0; data_o=0; busy_o=0; frame_done_o=0; last_result_o=0; overrun_o=0.
  - Buffer contents are don't-care.
- All outputs are registered except wr_ready_o, which is decoded directly from state (FILL → 1, else 0).
- FILL:
  - A word is accepted on a cycle with wr_valid_i & wr_ready_o. It is written to buf[wr_cnt], then wr_cnt increments.
  - When the accepted word makes wr_cnt = number_of_data, the next state is SEND and wr_cnt clears.
  - wr_ready_o drops in the cycle after the final accept.
- SEND:
  - Lasts exactly number_of_data consecutive cycles.
  - On the k-th SEND cycle (k = 0..N-1): start_o=1 and data_o=buf[k].
  - The first SEND cycle immediately follows the cycle of the final accept.
  - After the last word, state goes to WAIT. start_o returns to 0 and data_o to 0 in the same edge.
- WAIT:
  - Each cycle with result_valid_i=1 increments res_cnt and registers result_data_i into last_result_o.
  - When res_cnt would reach number_of_data:
    - frame_done_o pulses 1 on the next cycle;
    - res_cnt clears;
    - state returns to FILL, and wr_ready_o=1 in that same cycle.
  - There is no timeout; WAIT holds indefinitely until all results arrive.
- result_valid_i outside WAIT (FILL or SEND): the word is ignored, res_cnt is unchanged and overrun_o sets. overrun_o clears only by reset.
- wr_valid_i outside FILL: ignored with no side effects, because wr_ready_o=0 there.
- busy_o = 1 exactly while state is SEND or WAIT.
- Counter arithmetic: unsigned, cnt_width bits. No wrap occurs because each counter clears at number_of_data.
- Reset mid-SEND or mid-WAIT: all outputs go to reset values immediately and the partial frame is discarded. Downstream must also be reset by the same reset_n_i.

Decomposition:
- Shared package contents:
  - the state encoding (FILL=2'd0, SEND=2'd1, WAIT=2'd2);
  - data_size and number_of_data defaults, shared with the pipeline top.
- One sub-module is natural: softmax_vector_buffer, a number_of_data x data_size register file.
  - Write port: wr_en, wr_addr, wr_data. Read: combinational on rd_addr.
  - No reset on storage.
- The FSM and counters stay in softmax_stream_feeder.

Test Plan:
- Reset then fill: N=10, words 1..10 with wr_valid_i held high → 10 accepts on 10 cycles; wr_ready_o low in the cycle after the 10th accept; the next 10 cycles show start_o=1 with data_o=1,2,...,10; busy_o=1.
- Gapped fill: wr_valid_i toggling every other cycle → SEND still begins exactly one cycle after the 10th accept, and buffer order is preserved.
- Result counting: after SEND, drive 10 result_valid_i pulses with data 0xA0..0xA9, gaps allowed →
  - frame_done_o is a single-cycle pulse after the 10th pulse;
  - last_result_o=0xA9;
  - wr_ready_o=1 in the same cycle;
  - busy_o=0.
- Overrun: pulse result_valid_i during FILL → overrun_o=1 and stays 1 across a full subsequent frame; res_cnt is unaffected, so frame_done_o still fires after exactly 10 WAIT results.
- Reset mid-SEND: assert reset_n_i low on the 4th SEND cycle → start_o, data_o and busy_o go to 0 asynchronously. After release, state is FILL and the next frame 11..20 streams correctly.
- Back-to-back frames: two vectors written continuously → the second fill is accepted only after frame_done_o of the first, and no start_o gap occurs within a frame.
